// File: rtl/bsg_manycore_pkt_receive.sv
// Tile-side manycore packet receiver: 2-entry input FIFO, head decode into
// local memory stores, freeze-register config writes, and dropped-packet counting.
module bsg_manycore_pkt_receive #(
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 10,
  localparam int mask_width_lp   = data_width_p / 8,
  localparam int packet_width_lp = 2 + mask_width_lp + addr_width_p + data_width_p
                                   + 2 * (x_cord_width_p + y_cord_width_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [packet_width_lp-1:0] data_i,
  output logic                       ready_o,
  input  logic [x_cord_width_p-1:0]  my_x_i,
  input  logic [y_cord_width_p-1:0]  my_y_i,
  output logic                       mem_v_o,
  output logic [addr_width_p-1:0]    mem_addr_o,
  output logic [data_width_p-1:0]    mem_data_o,
  output logic [mask_width_lp-1:0]   mem_mask_o,
  input  logic                       mem_yumi_i,
  output logic                       freeze_o,
  output logic                       credit_o,
  output logic [7:0]                 err_count_o
);

  localparam int cord_w_lp  = x_cord_width_p + y_cord_width_p;
  // The sender coordinates are never consulted, so they are not stored.
  localparam int entry_w_lp = packet_width_lp - cord_w_lp;
  localparam int data_lo_lp = cord_w_lp;
  localparam int addr_lo_lp = data_lo_lp + data_width_p;
  localparam int mask_lo_lp = addr_lo_lp + addr_width_p;
  localparam int op_lo_lp   = mask_lo_lp + mask_width_lp;

  typedef enum logic [1:0] {
    op_drop_lo = 2'b00,
    op_store   = 2'b01,
    op_config  = 2'b10,
    op_drop_hi = 2'b11
  } op_e;

  logic [entry_w_lp-1:0] fifo_mem [2];
  logic [1:0]            count;
  logic                  wptr;
  logic                  rptr;
  logic                  enq;
  logic                  deq;
  logic                  unused_from;

  logic [entry_w_lp-1:0]     entry_in;
  logic [entry_w_lp-1:0]     head;
  op_e                       head_op;
  logic [x_cord_width_p-1:0] head_x;
  logic [y_cord_width_p-1:0] head_y;
  logic                      head_v;
  logic                      is_local;
  logic                      is_store;
  logic                      is_config;
  logic                      is_drop;

  assign entry_in    = {data_i[packet_width_lp-1:2*cord_w_lp], data_i[cord_w_lp-1:0]};
  assign unused_from = ^data_i[2*cord_w_lp-1:cord_w_lp];

  assign ready_o = reset_n_i & (count != 2'd2);
  assign enq     = v_i & ready_o;

  always_comb begin
    head      = fifo_mem[rptr];
    head_op   = op_e'(head[op_lo_lp +: 2]);
    head_x    = head[x_cord_width_p-1:0];
    head_y    = head[x_cord_width_p +: y_cord_width_p];
    head_v    = (count != 2'd0);
    is_local  = (head_x == my_x_i) && (head_y == my_y_i);
    is_store  = head_v && is_local && (head_op == op_store);
    is_config = head_v && is_local && (head_op == op_config);
    is_drop   = head_v && !is_store && !is_config;
    deq       = is_config || is_drop || (is_store && mem_yumi_i);
  end

  assign mem_v_o    = is_store;
  assign mem_addr_o = head[addr_lo_lp +: addr_width_p];
  assign mem_data_o = head[data_lo_lp +: data_width_p];
  assign mem_mask_o = head[mask_lo_lp +: mask_width_lp];

  // Payload storage carries no reset; validity lives entirely in count.
  always_ff @(posedge clk_i) begin
    if (enq) fifo_mem[wptr] <= entry_in;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else begin
      if (enq) wptr <= ~wptr;
      if (deq) rptr <= ~rptr;
      if (enq && !deq)      count <= count + 2'd1;
      else if (!enq && deq) count <= count - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      freeze_o    <= 1'b1;
      credit_o    <= 1'b0;
      err_count_o <= '0;
    end else begin
      credit_o <= deq;
      if (is_config && (mem_addr_o == '0)) freeze_o <= mem_data_o[0];
      if (is_drop && (err_count_o != '1)) err_count_o <= err_count_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_bsg_manycore_pkt_receive.sv
// Self-checking bench for bsg_manycore_pkt_receive: store scoreboard, vector
// table for head classification, and hand sequences for backpressure/reset.
module tb_bsg_manycore_pkt_receive;

  localparam int XW = 4;
  localparam int YW = 4;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MW = DW / 8;
  localparam int PW = 2 + MW + AW + DW + 2 * (XW + YW);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          v = 1'b0;
  logic [PW-1:0] pkt = '0;
  logic          ready;
  logic [XW-1:0] my_x = 4'd1;
  logic [YW-1:0] my_y = 4'd2;
  logic          mem_v;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [MW-1:0] mem_mask;
  logic          yumi = 1'b0;
  logic          freeze;
  logic          credit;
  logic [7:0]    err_count;

  bsg_manycore_pkt_receive #(
    .x_cord_width_p(XW),
    .y_cord_width_p(YW),
    .data_width_p  (DW),
    .addr_width_p  (AW)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (rst_n),
    .v_i        (v),
    .data_i     (pkt),
    .ready_o    (ready),
    .my_x_i     (my_x),
    .my_y_i     (my_y),
    .mem_v_o    (mem_v),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_data),
    .mem_mask_o (mem_mask),
    .mem_yumi_i (yumi),
    .freeze_o   (freeze),
    .credit_o   (credit),
    .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
  } exp_t;

  typedef struct {
    logic [1:0]    op;
    logic [MW-1:0] mask;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    bit            is_store;
    bit            is_drop;
    bit            freeze_after;
  } vec_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   credit_cnt = 0;
  int   memv_cnt = 0;
  bit   stream_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [1:0] op, input logic [MW-1:0] mask,
                                       input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                       input logic [XW-1:0] x, input logic [YW-1:0] y);
    return {op, mask, addr, data, 4'h6, 4'h5, y, x};
  endfunction

  task automatic push_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.mask = m;
    exp_q.push_back(e);
  endtask

  // Presents one packet and holds it until the handshake edge; returns at posedge+1.
  task automatic send(input logic [PW-1:0] p, output int waited);
    v = 1'b1;
    pkt = p;
    waited = 0;
    @(negedge clk);
    while (!ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready=0 want ready=1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    v = 1'b0;
  endtask

  always @(negedge clk) begin
    if (credit) credit_cnt++;
    if (mem_v) begin
      memv_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_store: got addr=%0h want no store", mem_addr);
      end else begin
        check("store_addr", 64'(mem_addr), 64'(exp_q[0].addr));
        check("store_data", 64'(mem_data), 64'(exp_q[0].data));
        check("store_mask", 64'(mem_mask), 64'(exp_q[0].mask));
        if (yumi) void'(exp_q.pop_front());
      end
    end
    if (stream_on) begin
      check("stream_ready", 64'(ready), 64'd1);
      check("stream_credit", 64'(credit), 64'd1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[9];
    int   w;
    int   c0;
    int   m0;
    int   exp_err;
    bit   exp_freeze;

    tbl[0] = '{2'b10, 4'h0, 10'h000, 32'h0000_0000, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{2'b10, 4'h0, 10'h004, 32'h0000_0001, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{2'b11, 4'hF, 10'h020, 32'h1111_1111, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{2'b01, 4'hF, 10'h030, 32'h2222_2222, 4'd3, 4'd2, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{2'b10, 4'h0, 10'h000, 32'h0000_0001, 4'd1, 4'd2, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{2'b00, 4'h3, 10'h040, 32'h3333_3333, 4'd1, 4'd2, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{2'b10, 4'h0, 10'h000, 32'h0000_0000, 4'd1, 4'd3, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{2'b01, 4'h5, 10'h3FF, 32'h1234_5678, 4'd1, 4'd2, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{2'b10, 4'h0, 10'h000, 32'h0000_0002, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_mem_v", 64'(mem_v), 64'd0);
    check("rst_credit", 64'(credit), 64'd0);
    check("rst_freeze", 64'(freeze), 64'd1);
    check("rst_err", 64'(err_count), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_err = 0;
    exp_freeze = 1'b1;

    // First store: mem_v the cycle after accept, single credit pulse after that.
    yumi = 1'b1;
    push_store(10'h010, 32'hDEAD_BEEF, 4'hF);
    send(mk(2'b01, 4'hF, 10'h010, 32'hDEAD_BEEF, 4'd1, 4'd2), w);
    check("first_wait", 64'(w), 64'd0);
    @(negedge clk);
    check("first_mem_v", 64'(mem_v), 64'd1);
    @(negedge clk);
    check("first_credit_hi", 64'(credit), 64'd1);
    check("first_mem_v_lo", 64'(mem_v), 64'd0);
    @(negedge clk);
    check("first_credit_lo", 64'(credit), 64'd0);

    // Backpressure: two fill the FIFO, the third waits for the first write.
    @(posedge clk);
    #1 yumi = 1'b0;
    c0 = credit_cnt;
    push_store(10'h100, 32'hA000_000A, 4'h1);
    push_store(10'h101, 32'hB000_000B, 4'h3);
    push_store(10'h102, 32'hC000_000C, 4'h8);
    send(mk(2'b01, 4'h1, 10'h100, 32'hA000_000A, 4'd1, 4'd2), w);
    send(mk(2'b01, 4'h3, 10'h101, 32'hB000_000B, 4'd1, 4'd2), w);
    v = 1'b1;
    pkt = mk(2'b01, 4'h8, 10'h102, 32'hC000_000C, 4'd1, 4'd2);
    repeat (5) begin
      @(negedge clk);
      check("bp_ready_low", 64'(ready), 64'd0);
    end
    @(posedge clk);
    #1 yumi = 1'b1;
    send(mk(2'b01, 4'h8, 10'h102, 32'hC000_000C, 4'd1, 4'd2), w);
    check("bp_third_wait", 64'(w), 64'd1);
    repeat (6) @(negedge clk);
    check("bp_credits", 64'(credit_cnt - c0), 64'd3);
    check("bp_drained", 64'(exp_q.size()), 64'd0);
    check("bp_ready_back", 64'(ready), 64'd1);

    // Head classification table, one packet at a time.
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      c0 = credit_cnt;
      m0 = memv_cnt;
      if (tbl[i].is_store) push_store(tbl[i].addr, tbl[i].data, tbl[i].mask);
      send(mk(tbl[i].op, tbl[i].mask, tbl[i].addr, tbl[i].data, tbl[i].x, tbl[i].y), w);
      @(negedge clk);
      check("tbl_freeze_hold", 64'(freeze), 64'(exp_freeze));
      repeat (3) @(negedge clk);
      if (tbl[i].is_drop) exp_err = exp_err + 1;
      exp_freeze = tbl[i].freeze_after;
      check("tbl_err", 64'(err_count), 64'(exp_err));
      check("tbl_freeze", 64'(freeze), 64'(exp_freeze));
      check("tbl_credit", 64'(credit_cnt - c0), 64'd1);
      check("tbl_mem_v", 64'(memv_cnt - m0), 64'(tbl[i].is_store));
      @(posedge clk);
      #1;
    end

    // Streaming stores at one per cycle.
    c0 = credit_cnt;
    for (int i = 0; i < 8; i++) begin
      push_store(AW'(10'h200 + i), 32'h5000_0000 + i, 4'hF);
      send(mk(2'b01, 4'hF, AW'(10'h200 + i), 32'h5000_0000 + i, 4'd1, 4'd2), w);
      check("stream_wait", 64'(w), 64'd0);
      if (i == 1) stream_on = 1'b1;
    end
    stream_on = 1'b0;
    repeat (4) @(negedge clk);
    check("stream_credits", 64'(credit_cnt - c0), 64'd8);
    check("stream_drained", 64'(exp_q.size()), 64'd0);

    // Error counter saturation.
    @(posedge clk);
    #1;
    c0 = credit_cnt;
    for (int i = 0; i < 300; i++) begin
      send(mk(2'b11, 4'h0, AW'(i), 32'(i), 4'd1, 4'd2), w);
    end
    repeat (3) @(negedge clk);
    exp_err = (exp_err + 300 > 255) ? 255 : exp_err + 300;
    check("sat_err", 64'(err_count), 64'(exp_err));
    check("sat_credits", 64'(credit_cnt - c0), 64'd300);

    // Reset with two stores queued: contents discarded, no credits.
    @(posedge clk);
    #1 yumi = 1'b0;
    push_store(10'h2AA, 32'h7777_7777, 4'hF);
    push_store(10'h2AB, 32'h8888_8888, 4'hF);
    send(mk(2'b01, 4'hF, 10'h2AA, 32'h7777_7777, 4'd1, 4'd2), w);
    send(mk(2'b01, 4'hF, 10'h2AB, 32'h8888_8888, 4'd1, 4'd2), w);
    check("mid_ready_full", 64'(ready), 64'd0);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_ready", 64'(ready), 64'd0);
    check("mid_rst_mem_v", 64'(mem_v), 64'd0);
    check("mid_rst_credit", 64'(credit), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    yumi = 1'b1;
    c0 = credit_cnt;
    m0 = memv_cnt;
    @(negedge clk);
    check("post_rst_freeze", 64'(freeze), 64'd1);
    check("post_rst_err", 64'(err_count), 64'd0);
    check("post_rst_ready", 64'(ready), 64'd1);
    repeat (3) @(negedge clk);
    check("post_rst_credits", 64'(credit_cnt - c0), 64'd0);
    check("post_rst_mem_v", 64'(memv_cnt - m0), 64'd0);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_pkt_receive.md
# bsg_manycore_pkt_receive

Tile-side receive endpoint for manycore packets produced by the tile packet encoder. It accepts packets from the network through a valid/ready handshake into a 2-entry FIFO, then decodes the packet at the FIFO head. Stores go to the local memory write port. Config writes update the freeze register. Misrouted or illegal packets are dropped and counted. One credit pulse goes back to the network for every packet retired.

## Interface
- x_cord_width_p, "inv", X coordinate width
- y_cord_width_p, "inv", Y coordinate width
- data_width_p, "inv", data width; must be a multiple of 8
- addr_width_p, "inv", word address width
- packet_width_lp, 2 + data_width_p/8 + addr_width_p + data_width_p + 2*(x_cord_width_p+y_cord_width_p), derived
- Packet packing, MSB to LSB: op[1:0], op_ex (byte mask), addr, data, from_y_cord, from_x_cord, y_cord, x_cord
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous assert, active-low; the block uses one clock and this reset is asynchronous and active-low
- v_i  in  1  incoming packet valid
- data_i  in  packet_width_lp  incoming packet
- ready_o  out  1  FIFO can accept a packet this cycle
- my_x_i  in  x_cord_width_p  this tile's X coordinate; quasi-static
- my_y_i  in  y_cord_width_p  this tile's Y coordinate; quasi-static
- mem_v_o  out  1  memory write request valid
- mem_addr_o  out  addr_width_p  write word address
- mem_data_o  out  data_width_p  write data
- mem_mask_o  out  data_width_p/8  byte write mask
- mem_yumi_i  in  1  memory accepts the request this cycle
- freeze_o  out  1  tile freeze register
- credit_o  out  1  one-cycle pulse, one per retired packet
- err_count_o  out  8  saturating count of dropped packets

## Operation
- FIFO: 2 entries, registered storage, no input-to-output bypass. ready_o = reset_n_i & (count != 2). A packet enqueues on v_i & ready_o.
- A head packet is "local" when x_cord == my_x_i and y_cord == my_y_i.
- Head classification and retirement:
  - op=01, local (STORE): drive mem_v_o=1, mem_addr_o=addr, mem_data_o=data, mem_mask_o=op_ex. The packet retires on mem_yumi_i. Outputs hold stable while waiting for yumi.
  - op=10, local (CONFIG): retires the same cycle it is at the head, without waiting. If addr==0, freeze_o <= data[0] at the next edge. Any other addr is ignored.
  - op=00 or 11, or any non-local packet (DROP): retires the same cycle. err_count_o increments and saturates at 255.
- mem_v_o is asserted only for STORE. mem_yumi_i is ignored when mem_v_o=0.
- Every retirement, of any type, registers credit_o=1 for exactly the next cycle.
- Dequeue and enqueue in the same cycle: count is unchanged. When full, ready_o=0 even if the head retires that cycle, because there is no bypass.
- No state machine beyond the FIFO count (0/1/2) plus read and write pointers. Pointers wrap modulo 2.

## Timing
- Reset values: count=0, pointers=0, freeze_o=1, credit_o=0, err_count_o=0, mem_v_o=0, ready_o=0 while reset_n_i is low.
- Reset asserted mid-operation: FIFO contents are discarded immediately, asynchronously, and no credit is issued for them.
- Latency:
  - Packet accepted at edge N: earliest mem_v_o is cycle N+1.
  - Earliest CONFIG/DROP retire is cycle N+1, with credit_o in N+2.
- Throughput: 1 packet/cycle when mem_yumi_i is tied high.
- STORE that sees mem_yumi_i in cycle M: credit_o=1 in M+1. The next head is presented in M+1.
- freeze_o and err_count_o update at the edge ending the retire cycle.

## Test plan
- Reset release, my=(1,2), STORE to (1,2), addr=0x10, data=0xDEADBEEF, mask=0xF, mem_yumi_i=1 -> mem_v_o in cycle after accept with those values; credit_o one pulse the cycle after.
- Three back-to-back STOREs with mem_yumi_i=0 for 5 cycles -> ready_o drops after 2 accepted, third held; mem outputs stable. Raise yumi -> 3 writes in order, 3 credit pulses, ready_o rises.
- CONFIG addr=0 data=0 -> freeze_o 1->0 next edge, credit once, mem_v_o never asserted; CONFIG addr=4 data=1 -> freeze_o stays 0.
- op=11 local, then STORE to (3,2) -> both dropped, err_count_o=2, two credits, no mem_v_o; 300 bad packets -> err_count_o=255.
- Streaming STOREs with mem_yumi_i=1 -> one enqueue and one retire per cycle, ready_o stays high, credit_o high continuously.
- reset_n_i pulsed low with 2 packets queued -> ready_o=0, mem_v_o=0, credit_o=0 immediately; after release count=0, freeze_o=1.
